vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
// - Source end of the pixel-coordinate interface: generates 640x480@60Hz VGA timing and drives xcount/ycount/indisplay.
// - Downstream blocks (row/col cell generator, renderers) consume these signals; hsync/vsync go to the VGA pins.
// - Divides the system clock into a pixel-rate enable, so the whole design stays on one clock domain.
// PARAMETERS
// - CLK_DIV   4    system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
// - H_ACTIVE  640  visible pixels per line
// - H_FP      16   horizontal front porch, pixels
// - H_SYNC    96   hsync pulse width, pixels
// - H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
// - V_ACTIVE  480  visible lines
// - V_FP      10   vertical front porch, lines
// - V_SYNC    2    vsync pulse width, lines
// - V_BP      33   vertical back porch, lines (V_TOTAL = 525)
// - SYNC_POL  0    active level of hsync/vsync (0 = active-low)
// PORTS
// - clk          in   1   system clock, all logic on rising edge
// - reset        in   1   synchronous, active-high
// - xcount       out  10  horizontal pixel counter, 0..H_TOTAL-1
// - ycount       out  10  vertical line counter, 0..V_TOTAL-1
// - indisplay    out  1   high when xcount<H_ACTIVE and ycount<V_ACTIVE
// - hsync        out  1   horizontal sync, level per SYNC_POL
// - vsync        out  1   vertical sync, level per SYNC_POL
// - pix_tick     out  1   one-clk enable; counters advance on the clk edge where it is high
// - line_start   out  1   one-clk pulse, coincident with xcount becoming 0 via tick
// - frame_start  out  1   one-clk pulse, coincident with (xcount,ycount) becoming (0,0) via tick
// BEHAVIOUR
// - Reset (synchronous): div counter=0, xcount=0, ycount=0, indisplay=0, pix_tick=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0.
// - Divider: div_cnt counts 0..CLK_DIV-1 and wraps; pix_tick=1 when div_cnt==CLK_DIV-1.
//   CLK_DIV=1: pix_tick=1 every clk after reset.
// - On a pix_tick edge: xcount+1. At H_TOTAL-1, xcount wraps to 0 and ycount advances; ycount wraps from V_TOTAL-1 to 0.
// - indisplay/hsync/vsync/line_start/frame_start are registers loaded from a decode of the NEXT counter values.
//   They therefore change on the same edge as xcount/ycount: zero-cycle skew relative to the coordinates.
// - hsync is active for xcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
// - vsync is active for ycount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
// - Guarantee to consumers: indisplay=1 implies xcount<=639 and ycount<=479 (cell index xcount/80, ycount/60 stays in 0..7).
// - First clk after reset deasserts: outputs reflect (0,0), so indisplay=1. No line_start or frame_start for this entry.
// - Simultaneous wrap (x=799, y=524 on tick): line_start and frame_start both pulse on the same clk.
// - Reset mid-frame: takes effect on the next edge regardless of div phase or counter values. No partial sync pulse is held.
// - Widths: counters are 10 bit; H_TOTAL and V_TOTAL must be <=1024 (checked by elaboration-time assertion).
// - Comparisons are unsigned against constants. No arithmetic overflow is possible.
// STRUCTURE
// - Shared package vga_timing_pkg holds the default timing constants and the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
//   The cell generator and renderers import the same constants.
// - One sub-module, pix_tick_gen: parameterised CLK_DIV counter producing pix_tick.
// - Counters, decode and output registers live in this module.
// TESTING
// - Reset held 10 clk -> xcount=ycount=0, indisplay=0, hsync=vsync=1, pulses 0.
//   Release -> next clk indisplay=1, no frame_start.
// - CLK_DIV=4 -> pix_tick high 1 clk in 4; xcount advances every 4 clk.
//   After 800 ticks, ycount=1 and line_start pulses exactly 1 clk.
// - Sync windows -> hsync low for exactly 96 ticks (x 656..751); vsync low for exactly 1600 ticks (y 490..491).
//   Both high elsewhere.
// - Full frame -> indisplay high for exactly 307200 ticks; never high with x>=640 or y>=480.
//   Frame period = 420000 ticks = 1680000 clk.
// - Wrap at (799,524) -> next tick gives (0,0) with frame_start and line_start both high for 1 clk.
// - Reset asserted at x=300, y=200, mid-div -> next clk all reset values.
//   Release -> counting restarts from (0,0).
//   Rebuild with CLK_DIV=1 and repeat the wrap check.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60Hz timing constants.
// Consumers (cell generator, renderers, sync generator) import these so that
// every block agrees on the raster geometry.
package vga_timing_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned MAX_CLK_DIV = 16;
  localparam int unsigned DEF_CLK_DIV = 4;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  // Pixel coordinate pair as seen by downstream consumers.
  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate enable generator.
// Ports: clk, reset (sync, active-high); pix_tick is high for one clk out of
// every CLK_DIV, and it is registered so it is 0 during reset.
module pix_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > MAX_CLK_DIV) begin : g_bad_div
    $error("pix_tick_gen: CLK_DIV out of range 1..16");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  // Wrapping phase counter.
  always_comb begin
    div_nxt = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_LAST) div_nxt = '0;
  end

  // pix_tick is loaded from the next phase so it is high while div_cnt==CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: pixel/line counters plus registered decode.
// Ports: clk, reset (sync, active-high); xcount/ycount coordinates;
// indisplay, hsync, vsync, pix_tick, line_start, frame_start.
// All decoded outputs are loaded from the next counter values so they change
// on the same edge as the coordinates.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = vga_timing_pkg::DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] xcount,
  output logic [9:0] ycount,
  output logic       indisplay,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CW       = vga_timing_pkg::CNT_W;
  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
  end

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          x_wrap;
  logic          y_wrap;

  // Next coordinates; advance only on a pixel tick.
  always_comb begin
    x_nxt  = xcount;
    y_nxt  = ycount;
    x_wrap = (xcount == CW'(H_TOT - 1));
    y_wrap = (ycount == CW'(V_TOT - 1));
    if (pix_tick) begin
      if (x_wrap) begin
        x_nxt = '0;
        y_nxt = y_wrap ? '0 : ycount + CW'(1);
      end else begin
        x_nxt = xcount + CW'(1);
      end
    end
  end

  // Coordinates and decode registered together: zero skew between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      xcount      <= '0;
      ycount      <= '0;
      indisplay   <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      xcount      <= x_nxt;
      ycount      <= y_nxt;
      indisplay   <= (x_nxt < CW'(H_ACTIVE)) && (y_nxt < CW'(V_ACTIVE));
      hsync       <= ((x_nxt >= CW'(HS_FIRST)) && (x_nxt <= CW'(HS_LAST))) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((y_nxt >= CW'(VS_FIRST)) && (y_nxt <= CW'(VS_LAST))) ? SYNC_POL : ~SYNC_POL;
      line_start  <= pix_tick && x_wrap;
      frame_start <= pix_tick && x_wrap && y_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance (CLK_DIV=4, active-low
// sync) and a shrunken-raster instance (CLK_DIV=1, active-high sync) share
// clock and reset. Expected outputs come from a closed-form model of the
// edge count since reset, queued at each rising edge and compared at the
// following falling edge.
module tb_vga_sync_gen;

  typedef logic [25:0] vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_ind, a_hs, a_vs, a_tick, a_ls, a_fs;
  logic b_ind, b_hs, b_vs, b_tick, b_ls, b_fs;

  vga_sync_gen #(
    .CLK_DIV  (4),
    .SYNC_POL (1'b0)
  ) dut_a (
    .clk (clk), .reset (reset), .xcount (a_x), .ycount (a_y),
    .indisplay (a_ind), .hsync (a_hs), .vsync (a_vs), .pix_tick (a_tick),
    .line_start (a_ls), .frame_start (a_fs)
  );

  vga_sync_gen #(
    .CLK_DIV (1),
    .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (5),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk (clk), .reset (reset), .xcount (b_x), .ycount (b_y),
    .indisplay (b_ind), .hsync (b_hs), .vsync (b_vs), .pix_tick (b_tick),
    .line_start (b_ls), .frame_start (b_fs)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Number of counter advances completed after edge j (edge 0 = reset edge).
  function automatic int unsigned adv(input int unsigned d, input int unsigned j);
    if (j == 0) return 0;
    return (d == 1) ? j - 1 : j / d;
  endfunction

  function automatic vec_t model(input int unsigned d, ha, hf, hs, hb, va, vf, vs, vb,
                                 input logic pol, input int unsigned k);
    int unsigned ht, vt, p, x, y;
    logic tick, moved, ind, hsy, vsy;
    if (k == 0) return {10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 1'b0};
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    p     = adv(d, k);
    moved = (p != adv(d, k - 1));
    x     = p % ht;
    y     = (p / ht) % vt;
    tick  = ((k % d) == d - 1);
    ind   = (x < ha) && (y < va);
    hsy   = (x >= ha + hf && x < ha + hf + hs) ? pol : ~pol;
    vsy   = (y >= va + vf && y < va + vf + vs) ? pol : ~pol;
    return {10'(x), 10'(y), ind, hsy, vsy, tick, moved && x == 0, moved && x == 0 && y == 0};
  endfunction

  vec_t q_a[$];
  vec_t q_b[$];
  int unsigned k = 0;

  // Scoreboard producer: expected state after this edge.
  always @(posedge clk) begin
    if (reset) k = 0;
    else k = k + 1;
    q_a.push_back(model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k));
    q_b.push_back(model(1, 10, 2, 3, 5, 6, 1, 2, 3, 1'b1, k));
  end

  logic after_mid = 1'b0;
  int a_hs_cnt = 0, a_hs_min = 1023, a_hs_max = 0, a_ind_cnt = 0, a_ls_cnt = 0, a_fs_cnt = 0;
  int b_ind_cnt = 0, b_vs_cnt = 0, b_hs_cnt = 0, b_fs_cnt = 0, b_ls_cnt = 0;
  int b_fs_k0 = 0, b_fs_k1 = 0, viol = 0;

  // Scoreboard consumer plus window statistics over edges 1..7000 of the first run.
  always @(negedge clk) begin
    if (q_a.size() != 0)
      check("a_out", 32'({a_x, a_y, a_ind, a_hs, a_vs, a_tick, a_ls, a_fs}), 32'(q_a.pop_front()));
    if (q_b.size() != 0)
      check("b_out", 32'({b_x, b_y, b_ind, b_hs, b_vs, b_tick, b_ls, b_fs}), 32'(q_b.pop_front()));
    if (a_ind && (a_x >= 640 || a_y >= 480)) viol++;
    if (b_ind && (b_x >= 10 || b_y >= 6)) viol++;
    if (!after_mid && k >= 1 && k <= 7000) begin
      if (a_tick) begin
        if (a_y == 0 && a_hs == 1'b0) begin
          a_hs_cnt++;
          if (int'(a_x) < a_hs_min) a_hs_min = int'(a_x);
          if (int'(a_x) > a_hs_max) a_hs_max = int'(a_x);
        end
        if (a_ind) a_ind_cnt++;
      end
      if (a_ls) a_ls_cnt++;
      if (a_fs) a_fs_cnt++;
      if (b_tick && k <= 240) begin
        if (b_ind) b_ind_cnt++;
        if (b_vs) b_vs_cnt++;
        if (b_hs) b_hs_cnt++;
      end
      if (b_ls) b_ls_cnt++;
      if (b_fs) begin
        b_fs_cnt++;
        if (b_fs_k0 == 0) b_fs_k0 = int'(k);
        else if (b_fs_k1 == 0) b_fs_k1 = int'(k);
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_a_xy",    32'({a_x, a_y}), 32'd0);
    check("rst_a_ind",   32'(a_ind), 32'd0);
    check("rst_a_sync",  32'({a_hs, a_vs}), 32'b11);
    check("rst_a_pulse", 32'({a_tick, a_ls, a_fs}), 32'd0);
    check("rst_b_sync",  32'({b_hs, b_vs}), 32'b00);
    reset = 1'b0;
    @(negedge clk);
    check("rel_a_ind", 32'(a_ind), 32'd1);
    check("rel_a_fs",  32'({a_ls, a_fs}), 32'd0);
    check("rel_b_ind", 32'(b_ind), 32'd1);
    check("rel_b_fs",  32'({b_ls, b_fs}), 32'd0);
    repeat (6999) @(negedge clk);
    // Mid-frame reset on the small raster at (7,3).
    waited = 0;
    while (!(b_x == 10'd7 && b_y == 10'd3) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("mid_wait", 32'(waited < 400), 32'd1);
    after_mid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_a_xy",   32'({a_x, a_y}), 32'd0);
    check("mid_a_sync", 32'({a_hs, a_vs, a_tick}), 32'b110);
    check("mid_b_all",  32'({b_x, b_y, b_ind, b_hs, b_vs, b_ls, b_fs}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rel_b_xy", 32'({b_x, b_y, b_ind}), 32'd1);
    check("mid_rel_b_fs", 32'({b_ls, b_fs}), 32'd0);
    repeat (2000) @(negedge clk);
    #1;
    check("a_hs_ticks",  32'(a_hs_cnt), 32'd96);
    check("a_hs_first",  32'(a_hs_min), 32'd656);
    check("a_hs_last",   32'(a_hs_max), 32'd751);
    check("a_ind_ticks", 32'(a_ind_cnt), 32'd1430);
    check("a_ls_pulses", 32'(a_ls_cnt), 32'd2);
    check("a_fs_pulses", 32'(a_fs_cnt), 32'd0);
    check("b_ind_frame", 32'(b_ind_cnt), 32'd60);
    check("b_vs_frame",  32'(b_vs_cnt), 32'd40);
    check("b_hs_frame",  32'(b_hs_cnt), 32'd36);
    check("b_ls_pulses", 32'(b_ls_cnt), 32'd349);
    check("b_fs_pulses", 32'(b_fs_cnt), 32'd29);
    check("b_fs_first",  32'(b_fs_k0), 32'd241);
    check("b_period",    32'(b_fs_k1 - b_fs_k0), 32'd240);
    check("ind_guard",   32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
